axppa_adder_arbiter: RTL

// - Shares one approximate Sklansky adder (Skalansky_Approx, K=8 variant) among NREQ requesters.
// - Round-robin arbitration; valid/ready on request and response sides; one op in flight.
// - Sits between accelerator lanes and the single adder instance, so area is spent once.
// - Optional exact-reference error monitor counts approximate-result mismatches.

---
 rtl/axppa_adder_arbiter_if.sv | 31 +++
 rtl/axppa_adder_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axppa_adder_arbiter_if.sv
// Request/response bundle between NREQ accelerator lanes and the shared adder arbiter.
// master = lanes/consumer side, slave = arbiter side.
interface axppa_adder_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ready;
    logic                  err_clear;
    logic                  err_flag;
    logic [15:0]           err_count;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready, err_clear,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, err_flag, err_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready, err_clear,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, err_flag, err_count
    );
endinterface

// File: rtl/axppa_adder_arbiter.sv
// Round-robin arbiter sharing one approximate Sklansky adder (K=8) among NREQ lanes; AXPPA_ERR_MON_EN adds an exact-sum error monitor.
// Latency: request handshake in cycle N gives rsp_valid in N+2; one op in flight, one op per 3 cycles.
// Backpressure: rsp_* hold while rsp_ready is low; req_ready stays low until the response is taken.

// Approximate adder: each K-bit segment is an exact Sklansky prefix adder; the carry into a segment
// is speculated from the previous segment's own generate, ignoring that segment's incoming carry.
// Purely combinational, no backpressure.
module axppa_sklansky_approx #(
    parameter int WIDTH = 16,
    parameter int K     = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSEG = WIDTH / K;
    localparam int LOGK = $clog2(K);

    // Returns group generates G[i:0] for every bit i.
    function automatic logic [K-1:0] sklansky(input logic [K-1:0] g_in, input logic [K-1:0] p_in);
        logic [K-1:0] g;
        logic [K-1:0] p;
        int           j;
        g = g_in;
        p = p_in;
        for (int l = 0; l < LOGK; l++) begin
            for (int i = 0; i < K; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j    = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        return g;
    endfunction

    logic [K-1:0] seg_a, seg_b, seg_p, seg_g, seg_gc, seg_c;
    logic         seg_ci;

    always_comb begin
        sum    = '0;
        cout   = 1'b0;
        seg_ci = cin;
        seg_a  = '0;
        seg_b  = '0;
        seg_p  = '0;
        seg_g  = '0;
        seg_gc = '0;
        seg_c  = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_a     = a[s*K +: K];
            seg_b     = b[s*K +: K];
            seg_p     = seg_a ^ seg_b;
            seg_g     = seg_a & seg_b;
            seg_gc    = seg_g;
            seg_gc[0] = seg_g[0] | (seg_p[0] & seg_ci);
            seg_c     = sklansky(seg_gc, seg_p);
            sum[s*K +: K] = seg_p ^ {seg_c[K-2:0], seg_ci};
            cout      = seg_c[K-1];
            seg_ci    = 1'(sklansky(seg_g, seg_p) >> (K - 1));
        end
    end
endmodule

module axppa_adder_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axppa_adder_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic             found;
    int               scan_idx;
    logic             hs;

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin;
    logic [IDW-1:0]   op_id;

    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // The adder only ever sees registered operands, so lane inputs never reach its carry tree.
    axppa_sklansky_approx #(.WIDTH(WIDTH), .K(8)) u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = IDW'(scan_idx);
            end
        end
    end

    assign hs = (state == S_IDLE) && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (found) state_nxt = S_COMPUTE;
            S_COMPUTE: state_nxt = S_RESP;
            S_RESP:    if (bus.rsp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Grant is gated by rst_n so req_ready reads zero during reset even with requests pending.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == S_IDLE && found) bus.req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            op_id       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            if (hs) begin
                op_a   <= bus.req_a[winner*WIDTH +: WIDTH];
                op_b   <= bus.req_b[winner*WIDTH +: WIDTH];
                op_cin <= bus.req_cin[winner];
                op_id  <= winner;
                rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            end
            if (state == S_COMPUTE) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= op_id;
                rsp_sum_q   <= add_sum;
                rsp_cout_q  <= add_cout;
            end else if (state == S_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;

`ifdef AXPPA_ERR_MON_EN
    logic [WIDTH:0] exact_sum;
    logic           mismatch;
    logic           err_flag_q;
    logic [15:0]    err_count_q;

    assign exact_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
    assign mismatch  = exact_sum != {add_cout, add_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (state == S_COMPUTE) err_flag_q <= mismatch;
            // A clear in the same cycle as a new mismatch takes priority.
            if (bus.err_clear)
                err_count_q <= '0;
            else if (state == S_COMPUTE && mismatch && err_count_q != 16'hFFFF)
                err_count_q <= err_count_q + 16'd1;
        end
    end

    assign bus.err_flag  = err_flag_q;
    assign bus.err_count = err_count_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = bus.err_clear;
    assign bus.err_flag     = 1'b0;
    assign bus.err_count    = '0;
`endif
endmodule
